// File: rtl/cpu_phase_gen_if.sv
// Control and phase-output bundle of the CPU phase generator.
// The master side drives run/halt/step and observes the phase outputs.
interface cpu_phase_gen_if;
  logic        run;
  logic        halt_req;
  logic        step;
  logic        ph0;
  logic        ph1_stb;
  logic        ph2_stb;
  logic        cyc_end;
  logic        halted;
  logic [15:0] cycles;

  modport master (
    output run, halt_req, step,
    input  ph0, ph1_stb, ph2_stb,
    input  cyc_end, halted, cycles
  );

  modport slave (
    input  run, halt_req, step,
    output ph0, ph1_stb, ph2_stb,
    output cyc_end, halted, cycles
  );
endinterface

// File: rtl/cpu_phase_gen.sv
// Master-clock CPU cycle generator: ph0 plus single-clock phase strobes,
// with free-run, stop-at-boundary and single-step control.
module cpu_phase_gen #(
  parameter int DIV      = 12,
  parameter int HIGH_CNT = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cpu_phase_gen_if.slave        phase_if
);

  localparam int LOW_CNT = DIV - HIGH_CNT;
  localparam int CW      = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] LOW_C = CW'(LOW_CNT);

  if (DIV < 2) begin : g_div_chk
    $error("cpu_phase_gen: DIV must be >= 2");
  end

  if (HIGH_CNT < 1 || HIGH_CNT > DIV - 1) begin : g_high_chk
    $error("cpu_phase_gen: HIGH_CNT must be in 1..DIV-1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_d;

  logic          ph0_q;
  logic          ph1_q;
  logic          ph2_q;
  logic          cyc_end_q;
  logic          halted_q;
  logic [15:0]   cycles_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        priority case (1'b1)
          phase_if.halt_req: state_d = IDLE;
          phase_if.run:      state_d = RUN;
          phase_if.step:     state_d = STEP;
          default:           state_d = IDLE;
        endcase
      end
      RUN: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (!phase_if.run || phase_if.halt_req) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STEP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign active_d = (state_d != IDLE);

  // Outputs are decoded from the next state so they line up with cnt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ph0_q     <= 1'b0;
      ph1_q     <= 1'b0;
      ph2_q     <= 1'b0;
      cyc_end_q <= 1'b0;
      halted_q  <= 1'b1;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ph0_q     <= active_d && (cnt_d >= LOW_C);
      ph1_q     <= active_d && (cnt_d == '0);
      ph2_q     <= active_d && (cnt_d == LOW_C);
      cyc_end_q <= active_d && (cnt_d == LAST);
      halted_q  <= !active_d;
      cycles_q  <= cycles_q + 16'(cyc_end_q);
    end
  end

  assign phase_if.ph0     = ph0_q;
  assign phase_if.ph1_stb = ph1_q;
  assign phase_if.ph2_stb = ph2_q;
  assign phase_if.cyc_end = cyc_end_q;
  assign phase_if.halted  = halted_q;
  assign phase_if.cycles  = cycles_q;

endmodule
